execute_stage: RTL and testbench
================================

# execute_stage

Execute stage plus EX/MEM pipeline register of the five-stage RV32 pipeline. It sits directly downstream of the ID/EX register and drives the memory stage. It forwards operands from EX/MEM and MEM/WB and computes ALU results in one cycle. MUL/MULH/MULHU run on an iterative 32-cycle shift-add multiplier that stalls the front of the pipe.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 is supported).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- IDEX_Execution  input  1  ID/EX slot holds a valid instruction (0 = bubble).
- IDEX_rs1, IDEX_rs2, IDEX_rd  input  5 each  register indices.
- IDEX_read_data1, IDEX_read_data2  input  32 each  register-file operands.
- IDEX_imm  input  32  sign-extended immediate.
- IDEX_AluSrc  input  1  1 = operand B is IDEX_imm.
- IDEX_aluOP  input  4  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 MULH, 13 MULHU; 14/15 behave as ADD.
- IDEX_aluOP_2  input  3  memory access funct3, passed through.
- IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite  input  1 each  control bits.
- MEMWB_rd  input  5  MEM/WB destination register.
- MEMWB_WriteBack  input  1  MEM/WB write enable.
- MEMEX_WriteBack  input  32  MEM/WB writeback data.
- EXMEM_alu_result  output  32  registered result / address.
- EXMEM_store_data  output  32  registered forwarded rs2.
- EXMEM_rd  output  5  registered destination.
- EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite  output  1 each  registered control.
- EXMEM_aluOP_2  output  3  registered access size.
- ex_stall  output  1  combinational; 1 = hold PC, IF/ID and ID/EX.

## Operation
- Forwarding for each of rs1 and rs2, evaluated independently:
  - Use EXMEM_alu_result if EXMEM_WriteBack=1, EXMEM_rd≠0 and EXMEM_rd matches the source index.
  - Otherwise use MEMEX_WriteBack if MEMWB_WriteBack=1, MEMWB_rd≠0 and MEMWB_rd matches.
  - Otherwise use the ID/EX operand.
  - EX/MEM takes priority over MEM/WB.
- Load-use hazards are resolved upstream by decode, so an EX/MEM load is never forwarded here.
- Operand A = forwarded rs1. Operand B = IDEX_imm if IDEX_AluSrc, else forwarded rs2. Store data is always forwarded rs2.
- Shifts use B[4:0]. SLT is signed; SLTU is unsigned. PASSB outputs B.
- All arithmetic wraps modulo 2^32.
- Multiplier FSM has three states: IDLE, BUSY, DONE.
  - IDLE: when a valid mul-class op is present, capture the operand magnitudes and sign, clear the 64-bit accumulator and the 5-bit counter, then go to BUSY.
  - BUSY: each cycle add the shifted multiplicand when multiplier bit i is 1, and increment the counter. After the iteration with counter=31, go to DONE.
  - DONE: apply sign correction to the 64-bit product, which is two's-complement negated when MULH operand signs differ. Present the result and return to IDLE.
  - MUL returns product[31:0]. MULH (signed×signed) and MULHU return product[63:32].
- ex_stall = 1 while a valid mul-class op is in ID/EX and the FSM is in IDLE or BUSY. It is 0 in DONE.
- EX/MEM update every cycle:
  - ex_stall=1: load a bubble (all control bits 0, rd=0, data 0).
  - IDEX_Execution=0: load a bubble.
  - Otherwise: load the result, forwarded rs2, rd, controls and aluOP_2.

## Timing
- ALU ops: 1-cycle latency. The result appears on EXMEM_* after the clock edge that follows the cycle the op is in ID/EX.
- MUL-class ops, accepted in cycle T:
  - ex_stall=1 during cycles T..T+32 (33 cycles).
  - BUSY spans T+1..T+32.
  - DONE is T+33 with ex_stall=0.
  - EX/MEM captures the product at the edge ending T+33.
- Operands are captured at T. Changes on the forwarding sources during BUSY are ignored.
- Back-to-back MULs: the second op enters ID/EX at T+34 and starts from IDLE. There is no lost cycle beyond the FSM latency.
- rst asserted at any time, including mid-multiply:
  - All EXMEM_* outputs go to 0 and the FSM goes to IDLE with counter 0.
  - ex_stall reflects only the current ID/EX contents.
- Reset values: EXMEM_alu_result=0, EXMEM_store_data=0, EXMEM_rd=0, EXMEM_WriteBack=0, EXMEM_MemoryRead=0, EXMEM_MemoryWrite=0, EXMEM_aluOP_2=0.

## Test plan
- ADD, rd=5, data1=7, imm=−3, AluSrc=1 -> EXMEM_alu_result=4 and EXMEM_rd=5 one edge later.
- Double hazard: EX/MEM writes x3=10 and MEM/WB writes x3=20; SUB x4 = x3−x3 with ID/EX data 99 -> operands both 10, result 0 (EX/MEM priority).
- rd=0 forwarding: EX/MEM writes x0=55, next op ADD x0+x0 with ID/EX data 0 -> result 0.
- MULH: 0xFFFFFFFE × 0x00000003 -> ex_stall high for exactly 33 cycles, 33 bubbles in EX/MEM, then EXMEM_alu_result=0xFFFFFFFF. MULHU with the same operands -> 0x00000002. MUL -> 0xFFFFFFFA.
- Store: MemoryWrite=1, rs2 forwarded from MEM/WB=0xDEADBEEF, imm=8, data1=0x100 -> address 0x108, EXMEM_store_data=0xDEADBEEF, aluOP_2 passed through.
- Assert rst at BUSY cycle 10 -> outputs 0 and FSM IDLE immediately. After release with the MUL still in ID/EX, the multiply restarts and completes 33 cycles later with the correct product.

Source files
------------

// File: rtl/execute_stage.sv
// RV32 execute stage and EX/MEM register: operand forwarding, one-cycle ALU, and a
// 32-iteration shift-add multiplier that holds the front of the pipe while it runs.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            IDEX_Execution,
    input  logic [4:0]      IDEX_rs1,
    input  logic [4:0]      IDEX_rs2,
    input  logic [4:0]      IDEX_rd,
    input  logic [XLEN-1:0] IDEX_read_data1,
    input  logic [XLEN-1:0] IDEX_read_data2,
    input  logic [XLEN-1:0] IDEX_imm,
    input  logic            IDEX_AluSrc,
    input  logic [3:0]      IDEX_aluOP,
    input  logic [2:0]      IDEX_aluOP_2,
    input  logic            IDEX_WriteBack,
    input  logic            IDEX_MemoryRead,
    input  logic            IDEX_MemoryWrite,

    input  logic [4:0]      MEMWB_rd,
    input  logic            MEMWB_WriteBack,
    input  logic [XLEN-1:0] MEMEX_WriteBack,

    output logic [XLEN-1:0] EXMEM_alu_result,
    output logic [XLEN-1:0] EXMEM_store_data,
    output logic [4:0]      EXMEM_rd,
    output logic            EXMEM_WriteBack,
    output logic            EXMEM_MemoryRead,
    output logic            EXMEM_MemoryWrite,
    output logic [2:0]      EXMEM_aluOP_2,
    output logic            ex_stall
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULH  = 4'd12;
    localparam logic [3:0] OP_MULHU = 4'd13;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [4:0]        shamt;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   ex_result;

    logic              is_mul_class;
    logic              mul_valid;
    logic              mulh_op;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    mul_state_t        mul_state;
    logic [2*XLEN-1:0] mul_mcand;
    logic [XLEN-1:0]   mul_mplier;
    logic [2*XLEN-1:0] mul_acc;
    logic [4:0]        mul_cnt;
    logic              mul_neg;
    logic              mul_hi;
    logic [2*XLEN-1:0] mul_product;
    logic [XLEN-1:0]   mul_result;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwd_a = IDEX_read_data1;
        if (EXMEM_WriteBack && (EXMEM_rd != 5'd0) && (EXMEM_rd == IDEX_rs1))
            fwd_a = EXMEM_alu_result;
        else if (MEMWB_WriteBack && (MEMWB_rd != 5'd0) && (MEMWB_rd == IDEX_rs1))
            fwd_a = MEMEX_WriteBack;
    end

    always_comb begin
        fwd_b = IDEX_read_data2;
        if (EXMEM_WriteBack && (EXMEM_rd != 5'd0) && (EXMEM_rd == IDEX_rs2))
            fwd_b = EXMEM_alu_result;
        else if (MEMWB_WriteBack && (MEMWB_rd != 5'd0) && (MEMWB_rd == IDEX_rs2))
            fwd_b = MEMEX_WriteBack;
    end

    assign op_a  = fwd_a;
    assign op_b  = IDEX_AluSrc ? IDEX_imm : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = op_a + op_b;
        case (IDEX_aluOP)
            OP_ADD:   alu_result = op_a + op_b;
            OP_SUB:   alu_result = op_a - op_b;
            OP_SLL:   alu_result = op_a << shamt;
            OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:   alu_result = op_a ^ op_b;
            OP_SRL:   alu_result = op_a >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(op_a) >>> shamt);
            OP_OR:    alu_result = op_a | op_b;
            OP_AND:   alu_result = op_a & op_b;
            OP_PASSB: alu_result = op_b;
            default:  alu_result = op_a + op_b;
        endcase
    end

    assign is_mul_class = (IDEX_aluOP == OP_MUL) || (IDEX_aluOP == OP_MULH) ||
                          (IDEX_aluOP == OP_MULHU);
    assign mul_valid    = IDEX_Execution && is_mul_class;
    assign mulh_op      = (IDEX_aluOP == OP_MULH);

    // Only MULH works on signed magnitudes; MUL's low word is sign-agnostic.
    assign a_mag = (mulh_op && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_mag = (mulh_op && op_b[XLEN-1]) ? -op_b : op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_state  <= MUL_IDLE;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= 5'd0;
            mul_neg    <= 1'b0;
            mul_hi     <= 1'b0;
        end else begin
            case (mul_state)
                MUL_IDLE: begin
                    if (mul_valid) begin
                        mul_mcand  <= {{XLEN{1'b0}}, a_mag};
                        mul_mplier <= b_mag;
                        mul_acc    <= '0;
                        mul_cnt    <= 5'd0;
                        mul_neg    <= mulh_op && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        mul_hi     <= (IDEX_aluOP != OP_MUL);
                        mul_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    // Multiplicand shifts left and multiplier right, so bit 0 is always bit i.
                    if (mul_mplier[0])
                        mul_acc <= mul_acc + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 5'd1;
                    if (mul_cnt == 5'd31)
                        mul_state <= MUL_DONE;
                end
                MUL_DONE: begin
                    mul_state <= MUL_IDLE;
                end
                default: begin
                    mul_state <= MUL_IDLE;
                end
            endcase
        end
    end

    assign mul_product = mul_neg ? -mul_acc : mul_acc;
    assign mul_result  = mul_hi ? mul_product[2*XLEN-1:XLEN] : mul_product[XLEN-1:0];
    assign ex_result   = is_mul_class ? mul_result : alu_result;

    assign ex_stall = mul_valid && (mul_state != MUL_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EXMEM_alu_result  <= '0;
            EXMEM_store_data  <= '0;
            EXMEM_rd          <= 5'd0;
            EXMEM_WriteBack   <= 1'b0;
            EXMEM_MemoryRead  <= 1'b0;
            EXMEM_MemoryWrite <= 1'b0;
            EXMEM_aluOP_2     <= 3'd0;
        end else if (ex_stall || !IDEX_Execution) begin
            EXMEM_alu_result  <= '0;
            EXMEM_store_data  <= '0;
            EXMEM_rd          <= 5'd0;
            EXMEM_WriteBack   <= 1'b0;
            EXMEM_MemoryRead  <= 1'b0;
            EXMEM_MemoryWrite <= 1'b0;
            EXMEM_aluOP_2     <= 3'd0;
        end else begin
            EXMEM_alu_result  <= ex_result;
            EXMEM_store_data  <= fwd_b;
            EXMEM_rd          <= IDEX_rd;
            EXMEM_WriteBack   <= IDEX_WriteBack;
            EXMEM_MemoryRead  <= IDEX_MemoryRead;
            EXMEM_MemoryWrite <= IDEX_MemoryWrite;
            EXMEM_aluOP_2     <= IDEX_aluOP_2;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, multiply/reset sequences, and random
// traffic checked against a behavioural pipeline model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        IDEX_Execution;
    logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [31:0] IDEX_read_data1, IDEX_read_data2, IDEX_imm;
    logic        IDEX_AluSrc;
    logic [3:0]  IDEX_aluOP;
    logic [2:0]  IDEX_aluOP_2;
    logic        IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite;
    logic [4:0]  MEMWB_rd;
    logic        MEMWB_WriteBack;
    logic [31:0] MEMEX_WriteBack;
    logic [31:0] EXMEM_alu_result, EXMEM_store_data;
    logic [4:0]  EXMEM_rd;
    logic        EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite;
    logic [2:0]  EXMEM_aluOP_2;
    logic        ex_stall;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .IDEX_Execution(IDEX_Execution), .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2),
        .IDEX_rd(IDEX_rd), .IDEX_read_data1(IDEX_read_data1),
        .IDEX_read_data2(IDEX_read_data2), .IDEX_imm(IDEX_imm),
        .IDEX_AluSrc(IDEX_AluSrc), .IDEX_aluOP(IDEX_aluOP), .IDEX_aluOP_2(IDEX_aluOP_2),
        .IDEX_WriteBack(IDEX_WriteBack), .IDEX_MemoryRead(IDEX_MemoryRead),
        .IDEX_MemoryWrite(IDEX_MemoryWrite),
        .MEMWB_rd(MEMWB_rd), .MEMWB_WriteBack(MEMWB_WriteBack),
        .MEMEX_WriteBack(MEMEX_WriteBack),
        .EXMEM_alu_result(EXMEM_alu_result), .EXMEM_store_data(EXMEM_store_data),
        .EXMEM_rd(EXMEM_rd), .EXMEM_WriteBack(EXMEM_WriteBack),
        .EXMEM_MemoryRead(EXMEM_MemoryRead), .EXMEM_MemoryWrite(EXMEM_MemoryWrite),
        .EXMEM_aluOP_2(EXMEM_aluOP_2), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        exec;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        src;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        wb, mr, mw;
        logic [4:0]  wrd;
        logic        wwb;
        logic [31:0] wdat;
        logic [31:0] e_res, e_sd;
        logic [4:0]  e_rd;
        logic [5:0]  e_ctl;
    } vec_t;

    vec_t vecs[16];
    int errors = 0;
    int checks = 0;

    // Expected EX/MEM contents, tracked by the model.
    logic [31:0] m_res, m_sd;
    logic [4:0]  m_rd;
    logic        m_wb, m_mr, m_mw;
    logic [2:0]  m_f3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        IDEX_Execution   = v.exec;
        IDEX_rs1         = v.rs1;
        IDEX_rs2         = v.rs2;
        IDEX_rd          = v.rd;
        IDEX_read_data1  = v.d1;
        IDEX_read_data2  = v.d2;
        IDEX_imm         = v.imm;
        IDEX_AluSrc      = v.src;
        IDEX_aluOP       = v.op;
        IDEX_aluOP_2     = v.f3;
        IDEX_WriteBack   = v.wb;
        IDEX_MemoryRead  = v.mr;
        IDEX_MemoryWrite = v.mw;
        MEMWB_rd         = v.wrd;
        MEMWB_WriteBack  = v.wwb;
        MEMEX_WriteBack  = v.wdat;
    endtask

    function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] regval);
        if (m_wb && m_rd != 0 && m_rd == rs) return m_res;
        if (MEMWB_WriteBack && MEMWB_rd != 0 && MEMWB_rd == rs) return MEMEX_WriteBack;
        return regval;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return $unsigned($signed(a) >>> b[4:0]);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return up[31:0];
            4'd12: return sp[63:32];
            4'd13: return up[63:32];
            default: return a + b;
        endcase
    endfunction

    task automatic chk_out(input string name, input logic [31:0] res, input logic [31:0] sd,
                           input logic [4:0] rd, input logic [5:0] ctl);
        chk({name, " result"}, EXMEM_alu_result, res);
        chk({name, " store"}, EXMEM_store_data, sd);
        chk({name, " rd"}, {27'd0, EXMEM_rd}, {27'd0, rd});
        chk({name, " ctl"}, {26'd0, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite,
                            EXMEM_aluOP_2}, {26'd0, ctl});
    endtask

    // Follows a multiply already in ID/EX: counts stall cycles and bubbles, then checks the product.
    task automatic wait_mul(input string name, input logic [31:0] exp, input logic [4:0] rd,
                            input logic [5:0] ctl);
        int n;
        int bub;
        n = 0;
        bub = 0;
        #1;
        while (ex_stall && n < 40) begin
            if (n == 5) begin
                MEMWB_rd        = IDEX_rs1;
                MEMWB_WriteBack = 1'b1;
                MEMEX_WriteBack = $urandom;
            end
            tick;
            n++;
            if (EXMEM_alu_result == 0 && EXMEM_store_data == 0 && EXMEM_rd == 0 &&
                !EXMEM_WriteBack && !EXMEM_MemoryRead && !EXMEM_MemoryWrite)
                bub++;
        end
        chk({name, " stall cycles"}, n, 33);
        chk({name, " bubbles"}, bub, 33);
        tick;
        chk({name, " product"}, EXMEM_alu_result, exp);
        chk({name, " rd"}, {27'd0, EXMEM_rd}, {27'd0, rd});
        chk({name, " ctl"}, {26'd0, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite,
                            EXMEM_aluOP_2}, {26'd0, ctl});
        m_res = exp; m_rd = rd;
        {m_wb, m_mr, m_mw, m_f3} = ctl;
    endtask

    task automatic run_mul(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        vec_t v;
        v = '{1'b1, 5'd20, 5'd21, 5'd25, a, b, 32'd0, 1'b0, op, 3'd0, 1'b1, 1'b0, 1'b0,
              5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 6'd0};
        apply(v);
        wait_mul(name, exp, 5'd25, 6'b100000);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [31:0] a, bb, b, exp;
        logic [31:0] ra, rb;

        // exec rs1 rs2 rd d1 d2 imm src op f3 wb mr mw | wrd wwb wdat | res sd rd ctl
        vecs[0]  = '{1, 1, 2, 5, 32'd7, 32'd0, 32'hFFFFFFFD, 1, 0, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd4, 32'd0, 5, 6'b100000};
        vecs[1]  = '{1, 6, 7, 3, 32'd10, 32'd0, 32'd0, 1, 0, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd10, 32'd0, 3, 6'b100000};
        vecs[2]  = '{1, 3, 3, 4, 32'd99, 32'd99, 32'd0, 0, 1, 0, 1, 0, 0, 3, 1, 32'd20,
                     32'd0, 32'd10, 4, 6'b100000};
        vecs[3]  = '{1, 8, 9, 0, 32'd55, 32'd0, 32'd0, 1, 0, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd55, 32'd0, 0, 6'b100000};
        vecs[4]  = '{1, 0, 0, 6, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 0, 1, 32'd77,
                     32'd0, 32'd0, 6, 6'b100000};
        vecs[5]  = '{1, 10, 11, 0, 32'h100, 32'd0, 32'd8, 1, 0, 3'b010, 0, 0, 1, 11, 1,
                     32'hDEADBEEF, 32'h108, 32'hDEADBEEF, 0, 6'b001010};
        vecs[6]  = '{0, 1, 2, 9, 32'd5, 32'd6, 32'd7, 1, 0, 3'b111, 1, 1, 0, 0, 0, 32'd0,
                     32'd0, 32'd0, 0, 6'b000000};
        vecs[7]  = '{1, 12, 13, 7, 32'h80000000, 32'd0, 32'd4, 1, 7, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'hF8000000, 32'd0, 7, 6'b100000};
        vecs[8]  = '{1, 13, 14, 8, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 3, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd1, 32'd1, 8, 6'b100000};
        vecs[9]  = '{1, 13, 14, 9, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 4, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd0, 32'd1, 9, 6'b100000};
        vecs[10] = '{1, 15, 16, 10, 32'd5, 32'd6, 32'h12345678, 1, 10, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'h12345678, 32'd6, 10, 6'b100000};
        vecs[11] = '{1, 17, 18, 11, 32'd5, 32'd6, 32'd0, 0, 15, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd11, 32'd6, 11, 6'b100000};
        vecs[12] = '{1, 11, 19, 12, 32'd999, 32'd3, 32'd1, 1, 0, 0, 1, 0, 0, 0, 0, 32'd0,
                     32'd12, 32'd3, 12, 6'b100000};
        vecs[13] = '{1, 20, 21, 13, 32'd3, 32'd0, 32'h21, 1, 2, 3'b100, 1, 1, 0, 0, 0, 32'd0,
                     32'd6, 32'd0, 13, 6'b110100};
        vecs[14] = '{1, 22, 23, 14, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 0, 5, 0, 1, 0, 0, 0, 0,
                     32'd0, 32'hFF00FF00, 32'h0FF00FF0, 14, 6'b100000};
        vecs[15] = '{1, 14, 24, 15, 32'd0, 32'hFFFF0000, 32'd0, 0, 9, 0, 1, 0, 0, 24, 1,
                     32'h12345678, 32'h12005600, 32'h12345678, 15, 6'b100000};

        rst = 1'b1;
        v = '{0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0,
              32'd0, 32'd0, 0, 6'd0};
        apply(v);
        tick;
        tick;
        chk_out("reset", 32'd0, 32'd0, 5'd0, 6'd0);
        chk("reset stall", {31'd0, ex_stall}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            tick;
            chk_out($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].e_sd, vecs[i].e_rd,
                    vecs[i].e_ctl);
            m_res = vecs[i].e_res; m_sd = vecs[i].e_sd; m_rd = vecs[i].e_rd;
            {m_wb, m_mr, m_mw, m_f3} = vecs[i].e_ctl;
        end

        // Asynchronous reset with a live EX/MEM entry.
        rst = 1'b1;
        #1;
        chk_out("async reset", 32'd0, 32'd0, 5'd0, 6'd0);
        tick;
        rst = 1'b0;

        run_mul("mulh", 4'd12, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF);
        run_mul("mulhu", 4'd13, 32'hFFFFFFFE, 32'h3, 32'h00000002);
        run_mul("mul", 4'd11, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA);

        // Reset in the tenth BUSY cycle, then restart with the multiply still in ID/EX.
        v = '{1, 5'd20, 5'd21, 5'd26, 32'h12345678, 32'h9ABCDEF1, 32'd0, 0, 4'd12, 3'd0,
              1, 0, 0, 5'd0, 0, 32'd0, 32'd0, 32'd0, 5'd0, 6'd0};
        apply(v);
        for (int i = 0; i < 10; i++) tick;
        rst = 1'b1;
        #1;
        chk_out("mid-mul reset", 32'd0, 32'd0, 5'd0, 6'd0);
        chk("mid-mul reset stall", {31'd0, ex_stall}, 32'd1);
        tick;
        tick;
        rst = 1'b0;
        m_wb = 1'b0; m_rd = 5'd0; m_res = 32'd0;
        wait_mul("restart mulh", alu_ref(4'd12, 32'h12345678, 32'h9ABCDEF1), 5'd26,
                 6'b100000);

        for (int i = 0; i < 200; i++) begin
            v.exec = ($urandom_range(0, 7) != 0);
            v.rs1  = 5'($urandom_range(0, 3));
            v.rs2  = 5'($urandom_range(0, 3));
            v.rd   = 5'($urandom_range(0, 3));
            ra     = $urandom;
            rb     = $urandom;
            v.d1   = ra;
            v.d2   = rb;
            v.imm  = $urandom;
            v.src  = 1'($urandom_range(0, 1));
            v.op   = 4'($urandom_range(0, 15));
            v.f3   = 3'($urandom_range(0, 7));
            v.wb   = 1'($urandom_range(0, 1));
            v.mr   = 1'($urandom_range(0, 1));
            v.mw   = 1'($urandom_range(0, 1));
            v.wrd  = 5'($urandom_range(0, 3));
            v.wwb  = 1'($urandom_range(0, 1));
            v.wdat = $urandom;
            apply(v);
            a   = fwd_ref(v.rs1, v.d1);
            bb  = fwd_ref(v.rs2, v.d2);
            b   = v.src ? v.imm : bb;
            exp = alu_ref(v.op, a, b);
            if (v.exec && v.op >= 4'd11 && v.op <= 4'd13) begin
                wait_mul($sformatf("rnd%0d mul", i), exp, v.rd, {v.wb, v.mr, v.mw, v.f3});
            end else begin
                tick;
                if (v.exec) begin
                    chk_out($sformatf("rnd%0d", i), exp, bb, v.rd, {v.wb, v.mr, v.mw, v.f3});
                    m_res = exp; m_sd = bb; m_rd = v.rd;
                    {m_wb, m_mr, m_mw, m_f3} = {v.wb, v.mr, v.mw, v.f3};
                end else begin
                    chk_out($sformatf("rnd%0d bubble", i), 32'd0, 32'd0, 5'd0, 6'd0);
                    m_res = 32'd0; m_sd = 32'd0; m_rd = 5'd0;
                    {m_wb, m_mr, m_mw, m_f3} = 6'd0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
